ahb_apb_master_fsm: RTL and testbench

- Control stage of the AHB-to-APB bridge, directly upstream of the bridge's HRESP decoder.
- Accepts AHB address/data phases, sequences the APB SETUP/ACCESS protocol, and stretches HREADYOUT.
- Produces reg_trans, p_sel and slave_error (APB watchdog timeout), which the response decoder consumes alongside p_slverr to form the 2-cycle AHB ERROR response.

---
 rtl/ahb_apb_pkg.sv | 27 ++
 rtl/ahb_apb_master_fsm_if.sv | 45 ++++
 rtl/apb_timeout_cnt.sv | 33 +++
 rtl/ahb_apb_master_fsm.sv | 132 +++++++++++++
 tb/tb_ahb_apb_master_fsm.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared types for the AHB-to-APB bridge: AHB HTRANS encodings and the APB
// master sequencer states. Also imported by the bridge's response decoder.
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HtIdle   = 2'b00,
    HtBusy   = 2'b01,
    HtNonseq = 2'b10,
    HtSeq    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    StIdle,
    StWwait,
    StSetup,
    StAccess,
    StAbort,
    StErr1,
    StErr2
  } apb_state_t;

  // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY start no transfer.
  function automatic logic htrans_active(logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/ahb_apb_master_fsm_if.sv
// Bus bundle for the bridge control stage.
//   master modport : the bridge FSM (AHB slave side in, APB master side out)
//   slave modport  : the environment around it (AHB master/decoder + APB slave)
// Signals: h_sel, h_trans, h_write, h_addr, h_wdata, h_ready_in, h_ready_out,
//          h_rdata, reg_trans, slave_error, p_sel, p_enable, p_write, p_addr,
//          p_wdata, p_ready, p_rdata, p_slverr.
interface ahb_apb_master_fsm_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              h_sel;
  logic [1:0]        h_trans;
  logic              h_write;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic              h_ready_in;
  logic              h_ready_out;
  logic [DATA_W-1:0] h_rdata;
  logic [1:0]        reg_trans;
  logic              slave_error;
  logic              p_sel;
  logic              p_enable;
  logic              p_write;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic              p_ready;
  logic [DATA_W-1:0] p_rdata;
  logic              p_slverr;

  modport master (
    input  h_sel, h_trans, h_write, h_addr, h_wdata, h_ready_in,
    input  p_ready, p_rdata, p_slverr,
    output h_ready_out, h_rdata, reg_trans, slave_error,
    output p_sel, p_enable, p_write, p_addr, p_wdata
  );

  modport slave (
    output h_sel, h_trans, h_write, h_addr, h_wdata, h_ready_in,
    output p_ready, p_rdata, p_slverr,
    input  h_ready_out, h_rdata, reg_trans, slave_error,
    input  p_sel, p_enable, p_write, p_addr, p_wdata
  );

endinterface

// File: rtl/apb_timeout_cnt.sv
// APB watchdog counter. Counts ACCESS cycles with p_ready low.
//   h_clk, h_reset : clock, asynchronous active-high reset
//   clr            : synchronous clear (takes priority over en)
//   en             : count one stalled cycle
//   tc             : high while the current stalled cycle is the TIMEOUT-th
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic h_clk,
  input  logic h_reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge h_clk or posedge h_reset) begin
    if (h_reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Flag the last permitted stall so the FSM aborts after exactly TIMEOUT cycles.
  assign tc = (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/ahb_apb_master_fsm.sv
// Control stage of the AHB-to-APB bridge. Accepts AHB transfers, runs the APB
// SETUP/ACCESS sequence, stretches HREADYOUT, and aborts stalled APB accesses
// via a watchdog (slave_error) feeding the downstream response decoder.
//   h_clk, h_reset : shared clock, asynchronous active-high reset
//   bus (master)   : AHB slave-side inputs, APB master-side outputs, plus
//                    reg_trans / slave_error for the response decoder
module ahb_apb_master_fsm
  import ahb_apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 h_clk,
  input  logic                 h_reset,
  ahb_apb_master_fsm_if.master bus
);

  apb_state_t        state_q;
  htrans_t           reg_trans_q;
  logic              p_sel_q;
  logic              p_enable_q;
  logic              p_write_q;
  logic              slave_error_q;
  logic [ADDR_W-1:0] p_addr_q;
  logic [DATA_W-1:0] p_wdata_q;

  logic ready_out;
  logic upd;
  logic accept;
  logic cnt_tc;

  // OKAY completion in ACCESS is combinational on p_ready so a zero-wait
  // access finishes in the same cycle the slave answers.
  assign ready_out = (state_q == StIdle) || (state_q == StErr2) ||
                     ((state_q == StAccess) && bus.p_ready && !bus.p_slverr);

  // A transfer boundary exists only where the bridge itself is ready; this keeps
  // reg_trans pinned through ABORT..ERR2 even if h_ready_in is driven high there.
  assign upd    = bus.h_ready_in && ready_out;
  assign accept = upd && bus.h_sel && htrans_active(bus.h_trans);

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_cnt (
    .h_clk   (h_clk),
    .h_reset (h_reset),
    .clr     (accept || (state_q == StWwait)),
    .en      ((state_q == StAccess) && !bus.p_ready),
    .tc      (cnt_tc)
  );

  always_ff @(posedge h_clk or posedge h_reset) begin
    if (h_reset) begin
      state_q       <= StIdle;
      reg_trans_q   <= HtIdle;
      p_sel_q       <= 1'b0;
      p_enable_q    <= 1'b0;
      p_write_q     <= 1'b0;
      slave_error_q <= 1'b0;
      p_addr_q      <= '0;
      p_wdata_q     <= '0;
    end else begin
      slave_error_q <= 1'b0;
      if (upd) begin
        reg_trans_q <= accept ? htrans_t'(bus.h_trans) : HtIdle;
      end
      if (accept) begin
        p_addr_q  <= bus.h_addr;
        p_write_q <= bus.h_write;
      end
      if (ready_out) begin
        // IDLE, ERR2 or OKAY completion: start the next transfer or go idle.
        p_enable_q <= 1'b0;
        if (accept) begin
          state_q <= bus.h_write ? StWwait : StSetup;
          p_sel_q <= !bus.h_write;
        end else begin
          state_q <= StIdle;
          p_sel_q <= 1'b0;
        end
      end else begin
        unique case (state_q)
          StWwait: begin
            p_wdata_q <= bus.h_wdata;
            state_q   <= StSetup;
            p_sel_q   <= 1'b1;
          end
          StSetup: begin
            state_q    <= StAccess;
            p_enable_q <= 1'b1;
          end
          StAccess: begin
            if (bus.p_ready) begin
              // Only PSLVERR reaches here; OKAY is handled above.
              state_q    <= StErr2;
              p_sel_q    <= 1'b0;
              p_enable_q <= 1'b0;
            end else if (cnt_tc) begin
              state_q       <= StAbort;
              p_enable_q    <= 1'b0;
              slave_error_q <= 1'b1;
            end
          end
          StAbort: begin
            state_q <= StErr1;
            p_sel_q <= 1'b0;
          end
          StErr1: begin
            state_q <= StErr2;
          end
          default: begin
            state_q    <= StIdle;
            p_sel_q    <= 1'b0;
            p_enable_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.h_ready_out = ready_out;
  assign bus.h_rdata     = bus.p_rdata;
  assign bus.reg_trans   = reg_trans_q;
  assign bus.slave_error = slave_error_q;
  assign bus.p_sel       = p_sel_q;
  assign bus.p_enable    = p_enable_q;
  assign bus.p_write     = p_write_q;
  assign bus.p_addr      = p_addr_q;
  assign bus.p_wdata     = p_wdata_q;

endmodule

// File: tb/tb_ahb_apb_master_fsm.sv
// Self-checking bench for ahb_apb_master_fsm (TIMEOUT = 4). Each table row is
// one clock cycle: inputs applied just after the rising edge, expected outputs
// pushed to a scoreboard and compared at the following falling edge.
module tb_ahb_apb_master_fsm;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  localparam logic [1:0]  HI = 2'b00;
  localparam logic [1:0]  BU = 2'b01;
  localparam logic [1:0]  NS = 2'b10;
  localparam logic [1:0]  SQ = 2'b11;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;

  // {h_ready_out, p_sel, p_enable, reg_trans, slave_error, p_write, p_addr, p_wdata, h_rdata}
  typedef logic [102:0] obs_t;
  typedef logic [105:0] chk_t;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdy_in;
    logic        prdy;
    logic        perr;
    logic [31:0] prdata;
    obs_t        exp;
  } vec_t;

  logic h_clk = 1'b0;
  logic h_reset;

  always #5 h_clk = ~h_clk;

  ahb_apb_master_fsm_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ahb_apb_master_fsm #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .h_clk   (h_clk),
    .h_reset (h_reset),
    .bus     (bus)
  );

  vec_t tbl[$];
  vec_t cur;
  obs_t sb_q[$];
  int   sb_row[$];
  int   checks = 0;
  int   errors = 0;

  task automatic si(input logic sel, input logic [1:0] trans, input logic wr,
                    input logic [31:0] addr, input logic [31:0] wdata, input logic rdy_in,
                    input logic prdy, input logic perr, input logic [31:0] prdata);
    cur.sel    = sel;
    cur.trans  = trans;
    cur.wr     = wr;
    cur.addr   = addr;
    cur.wdata  = wdata;
    cur.rdy_in = rdy_in;
    cur.prdy   = prdy;
    cur.perr   = perr;
    cur.prdata = prdata;
  endtask

  task automatic se(input logic hro, input logic psel, input logic pen, input logic [1:0] rt,
                    input logic serr, input logic pwr, input logic [31:0] paddr,
                    input logic [31:0] pwdata);
    cur.exp = {hro, psel, pen, rt, serr, pwr, paddr, pwdata, cur.prdata};
    tbl.push_back(cur);
  endtask

  task automatic drive(input vec_t v);
    bus.h_sel      = v.sel;
    bus.h_trans    = v.trans;
    bus.h_write    = v.wr;
    bus.h_addr     = v.addr;
    bus.h_wdata    = v.wdata;
    bus.h_ready_in = v.rdy_in;
    bus.p_ready    = v.prdy;
    bus.p_slverr   = v.perr;
    bus.p_rdata    = v.prdata;
  endtask

  function automatic obs_t observe();
    return {bus.h_ready_out, bus.p_sel, bus.p_enable, bus.reg_trans, bus.slave_error,
            bus.p_write, bus.p_addr, bus.p_wdata, bus.h_rdata};
  endfunction

  task automatic check(input string name, input chk_t act, input chk_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    obs_t e;
    obs_t a;
    int   r;

    h_reset = 1'b1;
    si(0, HI, 0, 0, 0, 1, 0, 0, 32'h1234);
    drive(cur);
    #12;
    check("reset_state", {observe(), dut.u_cnt.cnt_q},
          {1'b1, 1'b0, 1'b0, HI, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1234, 3'd0});
    @(negedge h_clk);
    h_reset = 1'b0;

    // Read, zero wait states.
    si(1, NS, 0, 32'h100, 0, 1, 0, 0, 0);        se(1, 0, 0, HI, 0, 0, 32'h0, 32'h0);
    si(0, HI, 0, 0, 0, 1, 0, 0, 0);              se(0, 1, 0, NS, 0, 0, 32'h100, 32'h0);
    si(0, HI, 0, 0, 0, 1, 1, 0, 32'hA5A5_0001);  se(1, 1, 1, NS, 0, 0, 32'h100, 32'h0);
    si(0, HI, 0, 0, 0, 1, 0, 0, 0);              se(1, 0, 0, HI, 0, 0, 32'h100, 32'h0);
    // Write, two wait states.
    si(1, NS, 1, 32'h204, 0, 1, 0, 0, 0);        se(1, 0, 0, HI, 0, 0, 32'h100, 32'h0);
    si(0, HI, 0, 0, DB, 1, 0, 0, 0);             se(0, 0, 0, NS, 0, 1, 32'h204, 32'h0);
    si(0, HI, 0, 0, 0, 1, 0, 0, 0);              se(0, 1, 0, NS, 0, 1, 32'h204, DB);
    si(0, HI, 0, 0, 0, 1, 0, 0, 0);              se(0, 1, 1, NS, 0, 1, 32'h204, DB);
    si(0, HI, 0, 0, 0, 1, 0, 0, 0);              se(0, 1, 1, NS, 0, 1, 32'h204, DB);
    si(0, HI, 0, 0, 0, 1, 1, 0, 0);              se(1, 1, 1, NS, 0, 1, 32'h204, DB);
    si(0, HI, 0, 0, 0, 1, 0, 0, 0);              se(1, 0, 0, HI, 0, 1, 32'h204, DB);
    // PSLVERR; h_ready_in low in ERR2 keeps reg_trans into the idle cycle.
    si(1, NS, 0, 32'h300, 0, 1, 0, 0, 0);        se(1, 0, 0, HI, 0, 1, 32'h204, DB);
    si(0, HI, 0, 0, 0, 1, 0, 0, 0);              se(0, 1, 0, NS, 0, 0, 32'h300, DB);
    si(0, HI, 0, 0, 0, 1, 1, 1, 0);              se(0, 1, 1, NS, 0, 0, 32'h300, DB);
    si(0, HI, 0, 0, 0, 0, 0, 0, 0);              se(1, 0, 0, NS, 0, 0, 32'h300, DB);
    si(0, HI, 0, 0, 0, 1, 0, 0, 0);              se(1, 0, 0, NS, 0, 0, 32'h300, DB);
    // Timeout: four stalled ACCESS cycles, ABORT, ERR1, ERR2.
    si(1, NS, 0, 32'h400, 0, 1, 0, 0, 0);        se(1, 0, 0, HI, 0, 0, 32'h300, DB);
    si(0, HI, 0, 0, 0, 1, 0, 0, 0);              se(0, 1, 0, NS, 0, 0, 32'h400, DB);
    for (int k = 0; k < 4; k++) begin
      si(0, HI, 0, 0, 0, 1, 0, 0, 0);            se(0, 1, 1, NS, 0, 0, 32'h400, DB);
    end
    si(0, HI, 0, 0, 0, 1, 0, 0, 0);              se(0, 1, 0, NS, 1, 0, 32'h400, DB);
    si(0, HI, 0, 0, 0, 1, 0, 0, 0);              se(0, 0, 0, NS, 0, 0, 32'h400, DB);
    si(0, HI, 0, 0, 0, 1, 0, 0, 0);              se(1, 0, 0, NS, 0, 0, 32'h400, DB);
    si(0, HI, 0, 0, 0, 1, 0, 0, 0);              se(1, 0, 0, HI, 0, 0, 32'h400, DB);
    // p_ready arrives in the last counted cycle: completion wins.
    si(1, NS, 0, 32'h500, 0, 1, 0, 0, 0);        se(1, 0, 0, HI, 0, 0, 32'h400, DB);
    si(0, HI, 0, 0, 0, 1, 0, 0, 0);              se(0, 1, 0, NS, 0, 0, 32'h500, DB);
    for (int k = 0; k < 3; k++) begin
      si(0, HI, 0, 0, 0, 1, 0, 0, 0);            se(0, 1, 1, NS, 0, 0, 32'h500, DB);
    end
    si(0, HI, 0, 0, 0, 1, 1, 0, 32'h5A5A);       se(1, 1, 1, NS, 0, 0, 32'h500, DB);
    si(0, HI, 0, 0, 0, 1, 0, 0, 0);              se(1, 0, 0, HI, 0, 0, 32'h500, DB);
    // Back-to-back NONSEQ then SEQ, then BUSY.
    si(1, NS, 0, 32'h600, 0, 1, 0, 0, 0);        se(1, 0, 0, HI, 0, 0, 32'h500, DB);
    si(0, HI, 0, 0, 0, 1, 0, 0, 0);              se(0, 1, 0, NS, 0, 0, 32'h600, DB);
    si(1, SQ, 0, 32'h604, 0, 1, 1, 0, 32'h11);   se(1, 1, 1, NS, 0, 0, 32'h600, DB);
    si(0, HI, 0, 0, 0, 1, 0, 0, 0);              se(0, 1, 0, SQ, 0, 0, 32'h604, DB);
    si(1, BU, 0, 32'h608, 0, 1, 1, 0, 32'h22);   se(1, 1, 1, SQ, 0, 0, 32'h604, DB);
    si(1, BU, 0, 32'h60C, 0, 1, 0, 0, 0);        se(1, 0, 0, HI, 0, 0, 32'h604, DB);
    si(0, HI, 0, 0, 0, 1, 0, 0, 0);              se(1, 0, 0, HI, 0, 0, 32'h604, DB);

    foreach (tbl[i]) begin
      @(posedge h_clk);
      #1;
      drive(tbl[i]);
      sb_q.push_back(tbl[i].exp);
      sb_row.push_back(i);
      @(negedge h_clk);
      e = sb_q.pop_front();
      r = sb_row.pop_front();
      a = observe();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL vec[%0d] got %h want %h", r, a, e);
      end
    end

    // Asynchronous reset while the APB access is stalled.
    @(posedge h_clk);
    #1;
    si(1, NS, 0, 32'h700, 0, 1, 0, 0, 0);
    drive(cur);
    @(posedge h_clk);
    #1;
    si(0, HI, 0, 0, 0, 1, 0, 0, 0);
    drive(cur);
    @(posedge h_clk);
    #1;
    @(posedge h_clk);
    #3;
    check("pre_reset_access", {observe(), dut.u_cnt.cnt_q},
          {1'b0, 1'b1, 1'b1, NS, 1'b0, 1'b0, 32'h700, DB, 32'h0, 3'd1});
    h_reset = 1'b1;
    #1;
    check("reset_mid_access", {observe(), dut.u_cnt.cnt_q},
          {1'b1, 1'b0, 1'b0, HI, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0});
    @(negedge h_clk);
    h_reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
